// File: rtl/cmp_bist_pkg.sv
// Shared definitions for the comparator BIST engine: golden-function mode
// codes and the sweep FSM state type.
package cmp_bist_pkg;

  localparam int MODE_EQ = 0;  // x == y
  localparam int MODE_GT = 1;  // x >  y (unsigned)
  localparam int MODE_LT = 2;  // x <  y (unsigned)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_golden.sv
// Golden comparator: expected result for operands x/y under the selected
// MODE. Purely combinational so it can also serve the comparator's own bench.
module cmp_golden
  import cmp_bist_pkg::*;
#(
  parameter int W    = 2,
  parameter int MODE = MODE_EQ
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         f
);

  // Select the reference relation; unknown mode codes fall back to equality.
  // NOTE: f is given a value before the case so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    f = 1'b0;
    case (MODE)
      MODE_GT: f = (x > y);
      MODE_LT: f = (x < y);
      default: f = (x == y);
    endcase
  end

endmodule

// File: rtl/cmp_bist_driver.sv
// Comparator BIST driver: sweeps {cmp_x, cmp_y} through every operand pair,
// holds each pair SETTLE cycles, checks cmp_f against cmp_golden on the last
// held cycle and reports busy/done/pass plus a saturating error count.
// Optional first-failure logging (fail_x/fail_y/fail_vld) is compiled in when
// the macro CMP_BIST_LOG_EN is defined.
module cmp_bist_driver
  import cmp_bist_pkg::*;
#(
  parameter int W      = 2,
  parameter int SETTLE = 1,
  parameter int MODE   = MODE_EQ,
  parameter int ERRW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cmp_f,
  output logic [W-1:0]    cmp_x,
  output logic [W-1:0]    cmp_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_cnt
`ifdef CMP_BIST_LOG_EN
  ,
  output logic [W-1:0]    fail_x,
  output logic [W-1:0]    fail_y,
  output logic            fail_vld
`endif
);

  localparam int VW = 2 * W;
  localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [HW-1:0]   HOLD_LAST = HW'(SETTLE - 1);
  localparam logic [VW-1:0]   V_LAST    = '1;
  localparam logic [ERRW-1:0] ERR_MAX   = '1;

  state_t          state;
  logic [VW-1:0]   v;         // vector index, cmp_x in the upper half
  logic [HW-1:0]   hold;      // cycles the current vector has been held
  logic            golden_f;
  logic            sample;    // last held cycle of the current vector
  logic            mismatch;
  logic [ERRW-1:0] err_next;

  assign {cmp_x, cmp_y} = v;

  cmp_golden #(
    .W    (W),
    .MODE (MODE)
  ) u_golden (
    .x (cmp_x),
    .y (cmp_y),
    .f (golden_f)
  );

  // Check strobe and saturating error-count increment for this cycle.
  always_comb begin
    sample   = (state == ST_RUN) && (hold == HOLD_LAST);
    mismatch = sample && (cmp_f != golden_f);
    err_next = err_cnt;
    if (mismatch && (err_cnt != ERR_MAX)) begin
      err_next = err_cnt + 1'b1;
    end
  end

  // Sweep FSM with registered status outputs; reset clears any partial result.
  // NOTE: all state here uses non-blocking assignments so every register
  // updates from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      v       <= '0;
      hold    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_RUN;
            v       <= '0;
            hold    <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
          end
        end
        ST_RUN: begin
          // start is deliberately not looked at here: a running sweep is never restarted.
          err_cnt <= err_next;
          if (hold != HOLD_LAST) begin
            hold <= hold + 1'b1;
          end else begin
            hold <= '0;
            if (v == V_LAST) begin
              // Last vector checked: finish instead of wrapping to vector 0.
              state <= ST_DONE;
              v     <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              v <= v + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          v     <= '0;
          hold  <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMP_BIST_LOG_EN
  // Capture the first failing vector of a sweep; later failures leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_x   <= '0;
      fail_y   <= '0;
      fail_vld <= 1'b0;
    end else if (start && (state != ST_RUN)) begin
      fail_x   <= '0;
      fail_y   <= '0;
      fail_vld <= 1'b0;
    end else if (mismatch && !fail_vld) begin
      fail_x   <= cmp_x;
      fail_y   <= cmp_y;
      fail_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_bist_driver.sv
// Bench for cmp_bist_driver. Five instances share clk/rst/start:
//   eq : W=2 SETTLE=1 MODE=EQ ERRW=8, cmp_f from truth table tt_eq
//   gt : W=2 SETTLE=1 MODE=GT ERRW=3, cmp_f from tt_gt (saturation case)
//   lt : W=2 SETTLE=1 MODE=LT ERRW=8, cmp_f from tt_lt
//   l3 : SETTLE=3 MODE=EQ behind an ideal 2-cycle-latency comparator
//   l1 : SETTLE=1 MODE=EQ behind the same latency comparator
module tb_cmp_bist_driver;
  import cmp_bist_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;

  int n_vec  = 0;
  int n_miss = 0;

  // Truth tables driving cmp_f, indexed by {cmp_x, cmp_y}.
  logic [15:0] tt_eq, tt_gt, tt_lt;

  logic [1:0] x_eq, y_eq, x_gt, y_gt, x_lt, y_lt, x_l3, y_l3, x_l1, y_l1;
  logic       f_eq, f_gt, f_lt, f_l3, f_l1;
  logic       busy_eq, busy_gt, busy_lt, busy_l3, busy_l1;
  logic       done_eq, done_gt, done_lt, done_l3, done_l1;
  logic       pass_eq, pass_gt, pass_lt, pass_l3, pass_l1;
  logic [7:0] err_eq, err_lt, err_l3, err_l1;
  logic [2:0] err_gt;
`ifdef CMP_BIST_LOG_EN
  logic [1:0] fx_eq, fy_eq, fx_gt, fy_gt, fx_lt, fy_lt, fx_l3, fy_l3, fx_l1, fy_l1;
  logic       fv_eq, fv_gt, fv_lt, fv_l3, fv_l1;
`endif

  assign f_eq = tt_eq[{x_eq, y_eq}];
  assign f_gt = tt_gt[{x_gt, y_gt}];
  assign f_lt = tt_lt[{x_lt, y_lt}];

  // Ideal equality comparator with two register stages of latency.
  logic l3_r1 = 1'b1, l3_r2 = 1'b1, l1_r1 = 1'b1, l1_r2 = 1'b1;
  always @(posedge clk) begin
    l3_r1 <= (x_l3 == y_l3);
    l3_r2 <= l3_r1;
    l1_r1 <= (x_l1 == y_l1);
    l1_r2 <= l1_r1;
  end
  assign f_l3 = l3_r2;
  assign f_l1 = l1_r2;

  // Busy-cycle counters, cleared by an accepted start.
  int bc_eq = 0, bc_l3 = 0;
  always @(posedge clk) begin
    if (start && !busy_eq) bc_eq <= 0;
    else if (busy_eq)      bc_eq <= bc_eq + 1;
    if (start && !busy_l3) bc_l3 <= 0;
    else if (busy_l3)      bc_l3 <= bc_l3 + 1;
  end

  cmp_bist_driver #(.W(2), .SETTLE(1), .MODE(MODE_EQ), .ERRW(8)) dut_eq (
    .clk(clk), .rst(rst), .start(start), .cmp_f(f_eq), .cmp_x(x_eq), .cmp_y(y_eq),
    .busy(busy_eq), .done(done_eq), .pass(pass_eq), .err_cnt(err_eq)
`ifdef CMP_BIST_LOG_EN
    , .fail_x(fx_eq), .fail_y(fy_eq), .fail_vld(fv_eq)
`endif
  );

  cmp_bist_driver #(.W(2), .SETTLE(1), .MODE(MODE_GT), .ERRW(3)) dut_gt (
    .clk(clk), .rst(rst), .start(start), .cmp_f(f_gt), .cmp_x(x_gt), .cmp_y(y_gt),
    .busy(busy_gt), .done(done_gt), .pass(pass_gt), .err_cnt(err_gt)
`ifdef CMP_BIST_LOG_EN
    , .fail_x(fx_gt), .fail_y(fy_gt), .fail_vld(fv_gt)
`endif
  );

  cmp_bist_driver #(.W(2), .SETTLE(1), .MODE(MODE_LT), .ERRW(8)) dut_lt (
    .clk(clk), .rst(rst), .start(start), .cmp_f(f_lt), .cmp_x(x_lt), .cmp_y(y_lt),
    .busy(busy_lt), .done(done_lt), .pass(pass_lt), .err_cnt(err_lt)
`ifdef CMP_BIST_LOG_EN
    , .fail_x(fx_lt), .fail_y(fy_lt), .fail_vld(fv_lt)
`endif
  );

  cmp_bist_driver #(.W(2), .SETTLE(3), .MODE(MODE_EQ), .ERRW(8)) dut_l3 (
    .clk(clk), .rst(rst), .start(start), .cmp_f(f_l3), .cmp_x(x_l3), .cmp_y(y_l3),
    .busy(busy_l3), .done(done_l3), .pass(pass_l3), .err_cnt(err_l3)
`ifdef CMP_BIST_LOG_EN
    , .fail_x(fx_l3), .fail_y(fy_l3), .fail_vld(fv_l3)
`endif
  );

  cmp_bist_driver #(.W(2), .SETTLE(1), .MODE(MODE_EQ), .ERRW(8)) dut_l1 (
    .clk(clk), .rst(rst), .start(start), .cmp_f(f_l1), .cmp_x(x_l1), .cmp_y(y_l1),
    .busy(busy_l1), .done(done_l1), .pass(pass_l1), .err_cnt(err_l1)
`ifdef CMP_BIST_LOG_EN
    , .fail_x(fx_l1), .fail_y(fy_l1), .fail_vld(fv_l1)
`endif
  );

  // ---------------- reference model ----------------
  typedef enum int { K_IDEAL, K_STUCK0, K_STUCK1, K_INV } kind_t;

  typedef struct {
    string name;
    kind_t kind;
    int    exp_eq;   // err_cnt of the EQ instance (ERRW=8)
    int    exp_gt;   // err_cnt of the GT instance (ERRW=3, saturates at 7)
    int    exp_lt;   // err_cnt of the LT instance (ERRW=8)
    int    exp_ff;   // first failing index on the EQ instance, -1 if none
  } vec_t;

  function automatic logic [15:0] golden_tt(int mode);
    logic [15:0] t;
    t = '0;
    for (int v = 0; v < 16; v++) begin
      int x;
      int y;
      x = v / 4;
      y = v % 4;
      if (mode == MODE_EQ)      t[v] = (x == y);
      else if (mode == MODE_GT) t[v] = (x > y);
      else                      t[v] = (x < y);
    end
    return t;
  endfunction

  function automatic logic [15:0] make_tt(kind_t k, int mode);
    case (k)
      K_STUCK0: return 16'h0000;
      K_STUCK1: return 16'hFFFF;
      K_INV:    return ~golden_tt(mode);
      default:  return golden_tt(mode);
    endcase
  endfunction

  function automatic int model_err(logic [15:0] tt, int mode, int errw);
    int n;
    int cap;
    n   = $countones(tt ^ golden_tt(mode));
    cap = (1 << errw) - 1;
    return (n > cap) ? cap : n;
  endfunction

  function automatic int model_first_fail(logic [15:0] tt, int mode);
    logic [15:0] d;
    d = tt ^ golden_tt(mode);
    for (int v = 0; v < 16; v++) if (d[v]) return v;
    return -1;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_all_done();
    int n;
    n = 0;
    while (!(done_eq && done_gt && done_lt && done_l3 && done_l1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sweep_completes", {31'd0, done_eq && done_gt && done_lt && done_l3 && done_l1}, 1);
  endtask

  task automatic check_sweep(input string tag, input int e_eq, input int e_gt, input int e_lt);
    check({tag, "_eq_done"}, {31'd0, done_eq}, 1);
    check({tag, "_eq_err"},  {24'd0, err_eq},  e_eq);
    check({tag, "_eq_pass"}, {31'd0, pass_eq}, (e_eq == 0) ? 1 : 0);
    check({tag, "_eq_busy_len"}, bc_eq, 16);
    check({tag, "_gt_err"},  {29'd0, err_gt},  e_gt);
    check({tag, "_gt_pass"}, {31'd0, pass_gt}, (e_gt == 0) ? 1 : 0);
    check({tag, "_lt_err"},  {24'd0, err_lt},  e_lt);
    check({tag, "_lt_pass"}, {31'd0, pass_lt}, (e_lt == 0) ? 1 : 0);
    check({tag, "_l3_pass"}, {31'd0, pass_l3}, 1);
    check({tag, "_l3_busy_len"}, bc_l3, 48);
    check({tag, "_l1_err_nonzero"}, {31'd0, err_l1 != 8'd0}, 1);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{"ideal",  K_IDEAL,   0, 0,  0, -1};
    tbl[1] = '{"stuck0", K_STUCK0,  4, 6,  6,  0};
    tbl[2] = '{"stuck1", K_STUCK1, 12, 7, 10,  1};
    tbl[3] = '{"inv",    K_INV,    16, 7, 16,  0};

    tt_eq = golden_tt(MODE_EQ);
    tt_gt = golden_tt(MODE_GT);
    tt_lt = golden_tt(MODE_LT);

    // start together with rst: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_beats_start_busy", {31'd0, busy_eq}, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy_eq}, 0);
    check("reset_done", {31'd0, done_eq}, 0);
    check("reset_pass", {31'd0, pass_eq}, 0);
    check("reset_err",  {24'd0, err_eq},  0);
    check("reset_xy",   {28'd0, x_eq, y_eq}, 0);
`ifdef CMP_BIST_LOG_EN
    check("reset_fail_vld", {31'd0, fv_eq}, 0);
`endif

    // Table-driven sweeps with fixed fault patterns.
    for (int i = 0; i < 4; i++) begin
      tt_eq = make_tt(tbl[i].kind, MODE_EQ);
      tt_gt = make_tt(tbl[i].kind, MODE_GT);
      tt_lt = make_tt(tbl[i].kind, MODE_LT);
      pulse_start();
      check({tbl[i].name, "_busy_after_start"}, {31'd0, busy_eq}, 1);
      wait_all_done();
      check_sweep(tbl[i].name, tbl[i].exp_eq, tbl[i].exp_gt, tbl[i].exp_lt);
`ifdef CMP_BIST_LOG_EN
      check({tbl[i].name, "_fail_vld"}, {31'd0, fv_eq}, (tbl[i].exp_ff >= 0) ? 1 : 0);
      if (tbl[i].exp_ff >= 0)
        check({tbl[i].name, "_fail_xy"}, {28'd0, fx_eq, fy_eq}, tbl[i].exp_ff);
`endif
    end

    // start while done (previous sweep had errors): restart and clear.
    tt_eq = golden_tt(MODE_EQ);
    tt_gt = golden_tt(MODE_GT);
    tt_lt = golden_tt(MODE_LT);
    pulse_start();
    check("restart_done_drops", {31'd0, done_eq}, 0);
    check("restart_busy",       {31'd0, busy_eq}, 1);
    check("restart_err_clear",  {24'd0, err_eq},  0);
    check("restart_gt_err_clear", {29'd0, err_gt}, 0);
`ifdef CMP_BIST_LOG_EN
    check("restart_fail_vld_clear", {31'd0, fv_eq}, 0);
`endif
    // start mid-sweep is ignored: busy length unchanged.
    repeat (5) @(negedge clk);
    pulse_start();
    wait_all_done();
    check_sweep("midstart", 0, 0, 0);

    // rst at vector 5 (x=01, y=01) after an error has been counted.
    tt_eq = 16'h0000;
    pulse_start();
    begin
      int n;
      n = 0;
      while (!(x_eq == 2'd1 && y_eq == 2'd1) && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("reach_vector5", {28'd0, x_eq, y_eq}, 5);
    end
    check("v5_err_before_rst", {24'd0, err_eq}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy_eq}, 0);
    check("midrst_done", {31'd0, done_eq}, 0);
    check("midrst_x",    {30'd0, x_eq},    0);
    check("midrst_err",  {24'd0, err_eq},  0);
    check("midrst_pass", {31'd0, pass_eq}, 0);
    tt_eq = golden_tt(MODE_EQ);
    pulse_start();
    wait_all_done();
    check_sweep("after_rst", 0, 0, 0);

    // Randomized fault patterns against the model.
    for (int r = 0; r < 8; r++) begin
      int e_eq, e_gt, e_lt;
      tt_eq = 16'($urandom);
      tt_gt = 16'($urandom);
      tt_lt = 16'($urandom);
      e_eq = model_err(tt_eq, MODE_EQ, 8);
      e_gt = model_err(tt_gt, MODE_GT, 3);
      e_lt = model_err(tt_lt, MODE_LT, 8);
      pulse_start();
      wait_all_done();
      check_sweep($sformatf("rand%0d", r), e_eq, e_gt, e_lt);
`ifdef CMP_BIST_LOG_EN
      begin
        int ff;
        ff = model_first_fail(tt_eq, MODE_EQ);
        check($sformatf("rand%0d_fail_vld", r), {31'd0, fv_eq}, (ff >= 0) ? 1 : 0);
        if (ff >= 0)
          check($sformatf("rand%0d_fail_xy", r), {28'd0, fx_eq, fy_eq}, ff);
      end
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
